// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: round-robin owner of the peripheral bus. Each granted
// request is run as a full ADDR / STROBE / RECOVER cycle on CS/ALE/rdb/wrb.
`default_nettype none

module bus_cycle_arbiter #(
   parameter int NREQ        = 4,
   parameter int AW          = 8,
   parameter int DW          = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      we,
   input  logic [NREQ*AW-1:0]   addr,
   input  logic [NREQ*DW-1:0]   wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [DW-1:0]        rdata,
   output logic                 CS,
   output logic                 ALE,
   output logic                 rdb,
   output logic                 wrb,
   output logic [AW-1:0]        bus_addr,
   output logic [DW-1:0]        bus_wdata,
   output logic                 bus_oe,
   input  logic [DW-1:0]        bus_rdata
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      ADDR    = 4'b0010,
      STROBE  = 4'b0100,
      RECOVER = 4'b1000
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            cs_q, cs_d;
   logic            ale_q, ale_d;
   logic            rdb_q, rdb_d;
   logic            wrb_q, wrb_d;
   logic [AW-1:0]   bus_addr_q, bus_addr_d;
   logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
   logic            bus_oe_q, bus_oe_d;

   logic            found;
   int              win;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic [NREQ-1:0] sel_gnt;
   logic [PW-1:0]   ptr_next;

   // Two passes give the wrap-around search: from ptr upward first, then from 0.
   always_comb begin
      found     = 1'b0;
      win       = 0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_gnt   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (i >= int'(ptr_q))) begin
            found = 1'b1;
            win   = i;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i]) begin
            found = 1'b1;
            win   = i;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (i == win) begin
            sel_we     = we[i];
            sel_addr   = addr[i*AW +: AW];
            sel_wdata  = wdata[i*DW +: DW];
            sel_gnt[i] = 1'b1;
         end
      end
      ptr_next = (win == NREQ - 1) ? '0 : PW'(win + 1);
   end

   // Outputs are computed for the state being entered so they are registered.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      rdata_d     = rdata_q;
      cs_d        = cs_q;
      ale_d       = ale_q;
      rdb_d       = rdb_q;
      wrb_d       = wrb_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_oe_d    = bus_oe_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = ADDR;
               ptr_d       = ptr_next;
               we_d        = sel_we;
               gnt_d       = sel_gnt;
               cs_d        = 1'b1;
               ale_d       = 1'b1;
               bus_addr_d  = sel_addr;
               bus_wdata_d = sel_wdata;
               bus_oe_d    = sel_we;
            end
         end
         ADDR: begin
            state_d = STROBE;
            ale_d   = 1'b0;
            rdb_d   = we_q;
            wrb_d   = !we_q;
            cnt_d   = '0;
         end
         STROBE: begin
            if (cnt_q == 3'(WAIT_CYCLES)) begin
               state_d  = RECOVER;
               cs_d     = 1'b0;
               rdb_d    = 1'b1;
               wrb_d    = 1'b1;
               bus_oe_d = 1'b0;
               done_d   = gnt_q;
               if (!we_q) rdata_d = bus_rdata;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         RECOVER: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            cs_d     = 1'b0;
            ale_d    = 1'b0;
            rdb_d    = 1'b1;
            wrb_d    = 1'b1;
            bus_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         gnt_q       <= '0;
         done_q      <= '0;
         rdata_q     <= '0;
         cs_q        <= 1'b0;
         ale_q       <= 1'b0;
         rdb_q       <= 1'b1;
         wrb_q       <= 1'b1;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_oe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         cs_q        <= cs_d;
         ale_q       <= ale_d;
         rdb_q       <= rdb_d;
         wrb_q       <= wrb_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_oe_q    <= bus_oe_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign CS        = cs_q;
   assign ALE       = ale_q;
   assign rdb       = rdb_q;
   assign wrb       = wrb_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_oe    = bus_oe_q;

endmodule

`default_nettype wire
